store_queue: RTL
================

STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter N_WAY, default 2: dispatch and execute lanes per cycle.
REQ-002 Parameter N_SQ, default 8: number of store-queue entries, indexed 1..N_SQ; index 0 means "none".
REQ-003 Parameter XLEN, default 32: address and data width.
REQ-004 Let IW = $clog2(N_SQ)+1, the index width.
REQ-005 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high.
REQ-007 Port disp_valid, input, N_WAY: lane i dispatches a store this cycle.
REQ-008 Port disp_idx, input, N_WAY x IW: SQ index allocated to lane i by dispatch.
REQ-009 Port ex_valid, input, N_WAY: lane i executed a store this cycle.
REQ-010 Port ex_idx, input, N_WAY x IW: SQ index of the executed store.
REQ-011 Port ex_addr and ex_data, input, N_WAY x XLEN each: store address and store data.
REQ-012 Port ex_size, input, N_WAY x 2: byte/half/word size code.
REQ-013 Port retire_store, input, 1: the ROB retires the oldest store this cycle.
REQ-014 Port branch_haz, input, 1: mispredict flush.
REQ-015 Port mem_ready, input, 1: memory accepts the request this cycle.
REQ-016 Port mem_req_valid, output, 1: a committed store is pending.
REQ-017 Port mem_req_addr and mem_req_data, output, XLEN each: address and data of that store.
REQ-018 Port mem_req_size, output, 2: size code of that store.
REQ-019 Port last_str_ex_idx, output, IW: youngest index whose store, and all older live stores, have executed; 0 when there is none.
REQ-020 Port sq_avail, output, $clog2(N_WAY)+1: number of consecutive FREE slots after tail, saturating at N_WAY.
REQ-021 Port sq_err, output, 1: sticky protocol-violation flag.

Function
REQ-022 Each entry SHALL hold a state (FREE, ALLOC, EXEC or RETIRED) plus addr, data and size.
REQ-023 head SHALL point to the oldest non-FREE slot and tail to the last allocated slot; both SHALL wrap N_SQ->1.
REQ-024 Dispatch: for each set disp_valid[i] in lane order, with disp_idx[i] == tail+1 (wrapped), the slot SHALL become ALLOC and tail SHALL advance; this visibility takes 1 cycle.
REQ-025 A dispatch whose index is out of order, or that targets a non-FREE slot, SHALL set sq_err and leave the slot unchanged.
REQ-026 Execute: ex_valid[i] on an ALLOC slot SHALL latch addr, data and size and move the slot to EXEC; on any other state it SHALL set sq_err.
REQ-027 Retire: retire_store SHALL move the oldest ALLOC/EXEC slot to RETIRED if it is EXEC; otherwise it SHALL set sq_err with no state change.
REQ-028 mem_req_valid SHALL equal 1 when the head slot is RETIRED, combinational from registered state, with 0-cycle latency to the outputs.
REQ-029 When mem_req_valid && mem_ready, the head slot SHALL become FREE and head SHALL advance past any FREE slots at the next edge.
REQ-030 branch_haz SHALL set every ALLOC/EXEC slot to FREE at the next edge.
REQ-031 On branch_haz, RETIRED slots SHALL be kept and drained normally.
REQ-032 On branch_haz, tail SHALL NOT roll back, because the dispatch index counter is not rewound; head SHALL skip the FREE holes this leaves.
REQ-033 If dispatch and branch_haz occur in the same cycle, the dispatch SHALL be dropped but tail SHALL still advance.
REQ-034 If execute and branch_haz occur in the same cycle, the flush SHALL win.
REQ-035 If retire and branch_haz occur in the same cycle, the retire SHALL apply first and the entry SHALL survive as RETIRED.
REQ-036 If drain and retire occur in the same cycle, both SHALL apply.
REQ-037 last_str_ex_idx SHALL be computed by scanning from head over non-FREE slots: it is the last index of the contiguous EXEC/RETIRED run, and 0 if the first live slot is ALLOC or no slot is live.
REQ-038 sq_avail SHALL be computed from registered state only; same-cycle frees SHALL NOT count.

Reset
REQ-039 On reset, all slots SHALL be FREE and head and tail SHALL be 0, so the first allocation is index 1.
REQ-040 On reset, sq_err SHALL be 0, mem_req_* SHALL be 0, last_str_ex_idx SHALL be 0, and sq_avail SHALL be N_WAY.
REQ-041 Reset during a pending mem request SHALL discard the request.

Verification
REQ-042 Dispatch idx 1,2; execute 2; then execute 1 -> last_str_ex_idx is 0, then 0, then 2.
REQ-043 Execute idx 1 (addr 0x100, data 0xAB), then retire, with mem_ready=0 for 3 cycles -> mem_req_valid holds 1 with addr 0x100 and data 0xAB; raising mem_ready frees the slot the next cycle.
REQ-044 Allocate 1..3, retire 1, then branch_haz -> slots 2 and 3 become FREE; slot 1 drains; the next dispatch uses idx 4 and head skips to 4.
REQ-045 Allocate 8 entries and drain them all, then dispatch idx 1 -> accepted (wrap); sq_avail is 2 when the queue is empty.
REQ-046 retire_store with the oldest slot ALLOC, or ex_valid on a FREE slot -> sq_err is 1 and remains 1 until reset.

Source files
------------

// File: rtl/store_queue.sv
// store_queue: in-order store queue. Stores are allocated at dispatch, filled
// at execute, marked RETIRED when the ROB retires them, and drained to memory
// from the head. A mispredict flush frees every ALLOC/EXEC slot.
// Handshake: mem_req_valid is a pure function of registered state and stays
// high until the cycle mem_ready is also high; that edge frees the head slot.
module store_queue #(
    parameter int N_WAY = 2,
    parameter int N_SQ  = 8,
    parameter int XLEN  = 32,
    localparam int IW   = $clog2(N_SQ) + 1,
    localparam int AW   = $clog2(N_WAY) + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_WAY-1:0]           disp_valid,
    input  logic [N_WAY-1:0][IW-1:0]   disp_idx,
    input  logic [N_WAY-1:0]           ex_valid,
    input  logic [N_WAY-1:0][IW-1:0]   ex_idx,
    input  logic [N_WAY-1:0][XLEN-1:0] ex_addr,
    input  logic [N_WAY-1:0][XLEN-1:0] ex_data,
    input  logic [N_WAY-1:0][1:0]      ex_size,
    input  logic                       retire_store,
    input  logic                       branch_haz,
    input  logic                       mem_ready,
    output logic                       mem_req_valid,
    output logic [XLEN-1:0]            mem_req_addr,
    output logic [XLEN-1:0]            mem_req_data,
    output logic [1:0]                 mem_req_size,
    output logic [IW-1:0]              last_str_ex_idx,
    output logic [AW-1:0]              sq_avail,
    output logic                       sq_err
);

    typedef enum logic [1:0] {S_FREE, S_ALLOC, S_EXEC, S_RETIRED} slot_state_e;

    // Slot 0 is never used; it keeps index 0 meaning "none".
    slot_state_e     state_q [0:N_SQ];
    slot_state_e     state_d [0:N_SQ];
    logic [XLEN-1:0] addr_q  [0:N_SQ];
    logic [XLEN-1:0] addr_d  [0:N_SQ];
    logic [XLEN-1:0] data_q  [0:N_SQ];
    logic [XLEN-1:0] data_d  [0:N_SQ];
    logic [1:0]      size_q  [0:N_SQ];
    logic [1:0]      size_d  [0:N_SQ];
    logic [IW-1:0]   head_q, head_d, tail_q, tail_d;
    logic            err_q, err_d;

    logic [IW-1:0]   start;
    logic [IW-1:0]   ret_scan, ret_ptr, disp_t, disp_nxt, head_scan, last_scan, last_idx, av_scan;
    logic            ret_found, head_found, last_stop, av_stop;
    logic [AW-1:0]   av_cnt;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x >= IW'(N_SQ)) ? IW'(1) : x + IW'(1);
    endfunction

    // Scans start at head; head 0 (straight out of reset) behaves like slot 1.
    assign start = (head_q == '0) ? IW'(1) : head_q;

    // Memory request is driven from the head slot when it is RETIRED.
    always_comb begin
        mem_req_valid = (head_q != '0) && (state_q[head_q] == S_RETIRED);
        mem_req_addr  = mem_req_valid ? addr_q[head_q] : '0;
        mem_req_data  = mem_req_valid ? data_q[head_q] : '0;
        mem_req_size  = mem_req_valid ? size_q[head_q] : '0;
    end

    // Locate the oldest ALLOC/EXEC slot, the retire candidate.
    always_comb begin
        ret_scan  = start;
        ret_ptr   = '0;
        ret_found = 1'b0;
        for (int k = 0; k < N_SQ; k++) begin
            if (!ret_found && (state_q[ret_scan] == S_ALLOC || state_q[ret_scan] == S_EXEC)) begin
                ret_found = 1'b1;
                ret_ptr   = ret_scan;
            end
            ret_scan = wrap_inc(ret_scan);
        end
    end

    // Slot update: drain, retire, execute, dispatch, then flush (flush wins last).
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        size_d   = size_q;
        err_d    = err_q;
        disp_t   = tail_q;
        disp_nxt = '0;

        if (mem_req_valid && mem_ready) begin
            state_d[head_q] = S_FREE;
        end

        if (retire_store) begin
            if (ret_found && state_q[ret_ptr] == S_EXEC) begin
                state_d[ret_ptr] = S_RETIRED;
            end else begin
                err_d = 1'b1;
            end
        end

        for (int i = 0; i < N_WAY; i++) begin
            if (ex_valid[i]) begin
                if (ex_idx[i] != '0 && ex_idx[i] <= IW'(N_SQ) && state_q[ex_idx[i]] == S_ALLOC) begin
                    state_d[ex_idx[i]] = S_EXEC;
                    addr_d[ex_idx[i]]  = ex_addr[i];
                    data_d[ex_idx[i]]  = ex_data[i];
                    size_d[ex_idx[i]]  = ex_size[i];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        // Tail follows the dispatch index counter even when a flush drops the store.
        for (int i = 0; i < N_WAY; i++) begin
            if (disp_valid[i]) begin
                disp_nxt = wrap_inc(disp_t);
                if (disp_idx[i] == disp_nxt && state_q[disp_nxt] == S_FREE) begin
                    if (!branch_haz) begin
                        state_d[disp_nxt] = S_ALLOC;
                    end
                    disp_t = disp_nxt;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        tail_d = disp_t;

        if (branch_haz) begin
            for (int p = 1; p <= N_SQ; p++) begin
                if (state_d[IW'(p)] == S_ALLOC || state_d[IW'(p)] == S_EXEC) begin
                    state_d[IW'(p)] = S_FREE;
                end
            end
        end
    end

    // Next head: first live slot from the current head, or one past tail when empty.
    always_comb begin
        head_d     = wrap_inc(tail_d);
        head_scan  = start;
        head_found = 1'b0;
        for (int k = 0; k < N_SQ; k++) begin
            if (!head_found && state_d[head_scan] != S_FREE) begin
                head_found = 1'b1;
                head_d     = head_scan;
            end
            head_scan = wrap_inc(head_scan);
        end
    end

    // Last index of the executed run starting at the oldest live slot.
    always_comb begin
        last_idx  = '0;
        last_scan = start;
        last_stop = 1'b0;
        for (int k = 0; k < N_SQ; k++) begin
            if (!last_stop) begin
                if (state_q[last_scan] == S_EXEC || state_q[last_scan] == S_RETIRED) begin
                    last_idx = last_scan;
                end else if (state_q[last_scan] == S_ALLOC) begin
                    last_stop = 1'b1;
                end
            end
            last_scan = wrap_inc(last_scan);
        end
    end

    // Consecutive free slots after tail, saturating at N_WAY.
    always_comb begin
        av_cnt  = '0;
        av_scan = tail_q;
        av_stop = 1'b0;
        for (int k = 0; k < N_WAY; k++) begin
            av_scan = wrap_inc(av_scan);
            if (!av_stop && state_q[av_scan] == S_FREE) begin
                av_cnt = av_cnt + AW'(1);
            end else begin
                av_stop = 1'b1;
            end
        end
    end

    assign last_str_ex_idx = last_idx;
    assign sq_avail        = av_cnt;
    assign sq_err          = err_q;

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= '{default: S_FREE};
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
            size_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            err_q   <= err_d;
        end
    end

endmodule
